shift_add_mult_ctrl: RTL and testbench

//   Sequential shift-and-add multiplier controller. Each cycle it routes one multiplier
//   bit and the multiplicand through the AND-partial-product / adder datapath,

---
 rtl/shift_add_mult_ctrl.sv | 102 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock,
// start/done handshake, 2*WIDTH-bit product held until the next start.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start, a, b     request and unsigned operands (taken in IDLE/DONE)
//   busy            high while iterating (WIDTH cycles)
//   done            one-cycle pulse when product becomes valid
//   product         a*b, stable from done until the next accepted start
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] pp;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  // acc_hi carries one extra bit so the add never drops its carry;
  // the whole {sum, acc_lo} pair then shifts right by one.
  always_comb begin
    pp     = mcand & {WIDTH{mplier[0]}};
    sum    = acc_hi + {1'b0, pp};
    hi_nxt = {1'b0, sum[WIDTH:1]};
    lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {hi_nxt[WIDTH-1:0], lo_nxt};
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: WIDTH=4 and WIDTH=8 instances checked
// each cycle against a countdown/a*b model, plus directed literal cases.
module tb_shift_add_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  product4;
  logic [15:0] product8;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  shift_add_mult_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
    .product(product4)
  );

  shift_add_mult_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: an accepted request occupies WIDTH busy cycles, then one
  // done cycle that publishes a*b of the captured operands.
  int          m4_left, m8_left;
  logic        m4_done, m8_done;
  logic [7:0]  m4_a, m4_b, m4_prod;
  logic [15:0] m8_a, m8_b, m8_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_left <= 0;
      m4_done <= 1'b0;
      m4_prod <= '0;
    end else if (m4_left != 0) begin
      m4_left <= m4_left - 1;
      m4_done <= (m4_left == 1);
      if (m4_left == 1) m4_prod <= m4_a * m4_b;
    end else begin
      m4_done <= 1'b0;
      if (start4) begin
        m4_left <= 4;
        m4_a    <= {4'd0, a4};
        m4_b    <= {4'd0, b4};
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_left <= 0;
      m8_done <= 1'b0;
      m8_prod <= '0;
    end else if (m8_left != 0) begin
      m8_left <= m8_left - 1;
      m8_done <= (m8_left == 1);
      if (m8_left == 1) m8_prod <= m8_a * m8_b;
    end else begin
      m8_done <= 1'b0;
      if (start8) begin
        m8_left <= 8;
        m8_a    <= {8'd0, a8};
        m8_b    <= {8'd0, b8};
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("m4_busy", busy4, m4_left != 0);
      chk("m4_done", done4, m4_done);
      chk("m4_prod", product4, m4_prod);
      chk("m8_busy", busy8, m8_left != 0);
      chk("m8_done", done8, m8_done);
      chk("m8_prod", product8, m8_prod);
      chk("m4_excl", busy4 & done4, 0);
      chk("m8_excl", busy8 & done8, 0);
    end
  end

  // One operation with literal expectations for timing and result.
  task automatic op(input bit w8, input logic [7:0] x,
                    input logic [7:0] y, input logic [15:0] exp,
                    input string nm);
    int td = -1;
    int nb = 0;
    int w  = w8 ? 8 : 4;
    logic [15:0] p;
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; a8 = x; b8 = y;
    end else begin
      start4 = 1'b1; a4 = x[3:0]; b4 = y[3:0];
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start4 = 1'b0; start8 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (w8 ? busy8 : busy4) nb++;
      if (w8 ? done8 : done4) begin
        td = i;
        break;
      end
    end
    p = w8 ? product8 : {8'd0, product4};
    chk({nm, "_prod"}, p, exp);
    chk({nm, "_busy"}, nb, w);
    chk({nm, "_lat"}, td, w + 1);
  endtask

  initial begin
    int t1, t2, td, n8;
    rst_n  = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_prod4", product4, 0);
    chk("rst_prod8", product8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(0, 8'h5, 8'h3, 16'h0F, "t1_5x3");
    op(0, 8'hF, 8'hF, 16'hE1, "t2_fxf");
    op(0, 8'h0, 8'hA, 16'h00, "t2_zero");

    // start held high: back-to-back operations
    t1 = -1; t2 = -1;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd3;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done4) begin
        if (t1 < 0) begin
          t1 = i;
          chk("t3_prod1", product4, 8'h06);
          a4 = 4'd7; b4 = 4'd7;
        end else begin
          t2 = i;
          chk("t3_prod2", product4, 8'h31);
          break;
        end
      end
    end
    start4 = 1'b0;
    chk("t3_gap", t2 - t1, 5);

    // start pulsed mid-CALC must be ignored
    td = -1;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start4 = 1'b0;
      if (i == 2) begin start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; end
      if (i == 3) start4 = 1'b0;
      if (done4) begin td = i; break; end
    end
    chk("t4_prod", product4, 8'h2A);
    chk("t4_lat", td, 5);

    // reset in the middle of CALC (after two iterations)
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy4, 0);
    chk("t5_done", done4, 0);
    chk("t5_prod", product4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_nodone", done4, 0);
    end
    op(0, 8'h5, 8'h3, 16'h0F, "t5_after");

    op(1, 8'hFF, 8'hFF, 16'hFE01, "t6_ffxff");
    op(1, 8'h00, 8'h00, 16'h0000, "t6_zero");
    op(1, 8'h80, 8'h02, 16'h0100, "t6_pow2");

    // random sweep on both widths, model checks every cycle
    n8 = 0;
    for (int c = 0; c < 30000 && n8 < 1000; c++) begin
      @(negedge clk);
      if (done8) n8++;
      start4 = ($urandom_range(0, 3) != 0);
      start8 = ($urandom_range(0, 3) != 0);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    chk("t6_rand_count", n8, 1000);
    start4 = 1'b0; start8 = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
